mem_access_unit: RTL and testbench

- Load/store front end sitting between the processor's memory stage and the asynchronous data memory.
- Accepts one load or store request at a time over a valid/ready handshake, checks it for alignment and address-window errors, and drives the memory port for exactly one cycle.
- Aligns and sign/zero-extends load data, then holds the result on a valid/ready response channel.
- Byte-lane replication and write-enable decode remain in the memory; this block presents the raw address, data and size code.

---
 rtl/mem_access_unit_pkg.sv | 49 ++++
 rtl/mem_access_unit_if.sv | 55 +++++
 rtl/mem_access_unit_load_align.sv | 48 ++++
 rtl/mem_access_unit.sv | 122 ++++++++++++
 tb/tb_mem_access_unit.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg
//   Shared definitions for the load/store front end: access size codes,
//   position of the unsigned-load bit in the op field, response error bit
//   indices, the control FSM state type, and the request checker used when
//   a request is accepted.
// ---------------------------------------------------------------------------
package mem_access_pkg;

   // Size codes carried in op[1:0] and passed unchanged to the memory.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_ILL  = 2'b10,
      SZ_WORD = 2'b11
   } size_t;

   // op[OP_UNSIGNED] selects zero extension on loads.
   localparam logic [1:0] OP_UNSIGNED = 2'd2;

   // Bit positions inside the 2-bit response error code.
   localparam logic ERR_ALIGN = 1'b0;
   localparam logic ERR_RANGE = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      RESP   = 2'b10
   } state_t;

   // Error code for a request: alignment/illegal size and address window.
   function automatic logic [1:0] access_err(
      input logic [31:0] addr,
      input logic [1:0]  size,
      input logic [15:0] window
   );
      logic [1:0] err;
      err = '0;
      unique case (size)
         SZ_BYTE: err[ERR_ALIGN] = 1'b0;
         SZ_HALF: err[ERR_ALIGN] = addr[0];
         SZ_ILL:  err[ERR_ALIGN] = 1'b1;
         default: err[ERR_ALIGN] = |addr[1:0];
      endcase
      err[ERR_RANGE] = (addr[31:16] != window);
      return err;
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
//   Bundles the three channels of the load/store front end:
//     req_*  : request from the memory stage (valid/ready handshake)
//     mem_*  : port to the asynchronous data memory
//     rsp_*  : response back to the pipeline (valid/ready handshake)
//   Modports:
//     slave  : the mem_access_unit itself
//     master : the surrounding pipeline + memory (request source, read data
//              source, response sink)
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
   import mem_access_pkg::*;

   // request channel
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   // memory port
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   size_t       mem_size;
   logic        mem_we;
   logic        mem_re;
   logic [31:0] mem_rdata;

   // response channel
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;

   modport slave (
      input  req_valid, req_we, req_op, req_addr, req_wdata,
      output req_ready,
      output mem_addr, mem_wdata, mem_size, mem_we, mem_re,
      input  mem_rdata,
      output rsp_valid, rsp_rdata, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_we, req_op, req_addr, req_wdata,
      input  req_ready,
      input  mem_addr, mem_wdata, mem_size, mem_we, mem_re,
      output mem_rdata,
      input  rsp_valid, rsp_rdata, rsp_err,
      output rsp_ready
   );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Combinational load-data extraction. Picks the addressed byte or half
//   lane from the raw memory word and sign- or zero-extends it to 32 bits.
//   Ports:
//     rdata : raw 32-bit word from the memory
//     addr  : low two address bits of the access
//     op    : access op, [1:0] size code, [2] unsigned
//     data  : extended load result
// ---------------------------------------------------------------------------
module load_align
   import mem_access_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  op,
   output logic [31:0] data
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic        sign_ext;

   always_comb begin
      byte_lane = rdata[7:0];
      half_lane = rdata[15:0];
      sign_ext  = ~op[OP_UNSIGNED];
      data      = rdata;

      unique case (addr)
         2'd0: byte_lane = rdata[7:0];
         2'd1: byte_lane = rdata[15:8];
         2'd2: byte_lane = rdata[23:16];
         2'd3: byte_lane = rdata[31:24];
      endcase

      if (addr[1]) begin
         half_lane = rdata[31:16];
      end

      unique case (op[1:0])
         SZ_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
         SZ_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store front end between the memory stage and the asynchronous data
//   memory. Takes one request at a time, checks alignment and the address
//   window, drives the memory port for exactly one cycle, and returns the
//   extended load data (or an error code) on a held response channel.
//   Byte-lane replication and write-enable decode are left to the memory.
//   Parameters:
//     MEM_ADDR : required value of req_addr[31:16] for a legal access
//   Ports:
//     clock    : single clock, rising edge
//     reset_n  : asynchronous active-low reset
//     bus      : request / memory / response channels (slave side)
// ---------------------------------------------------------------------------
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter logic [15:0] MEM_ADDR = 16'h1000
) (
   input  logic             clock,
   input  logic             reset_n,
   mem_access_unit_if.slave bus
);

   state_t      state;
   state_t      state_next;
   logic        accept;
   logic [1:0]  req_err;
   logic        uns_q;
   logic [31:0] load_data;

   assign accept  = bus.req_valid & bus.req_ready;
   assign req_err = access_err(bus.req_addr, bus.req_op[1:0], MEM_ADDR);

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               // A rejected request skips the memory and answers at once.
               state_next = (req_err != '0) ? RESP : ACCESS;
            end
         end
         ACCESS: state_next = RESP;
         RESP: begin
            if (bus.rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Load data extraction from the memory word being read this cycle.
   // mem_size still holds the latched size during ACCESS.
   // ------------------------------------------------------------------
   load_align u_load_align (
      .rdata (bus.mem_rdata),
      .addr  (bus.mem_addr[1:0]),
      .op    ({uns_q, bus.mem_size}),
      .data  (load_data)
   );

   // ------------------------------------------------------------------
   // Registered outputs. req_ready/rsp_valid are registered from the next
   // state so req_ready stays low through reset and only rises at the
   // first edge after release. mem_we/mem_re are set on acceptance and
   // cleared unconditionally one edge later, giving a one-cycle strobe
   // that the asynchronous reset can kill before the store commits.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_size  <= SZ_BYTE;
         bus.mem_we    <= 1'b0;
         bus.mem_re    <= 1'b0;
         uns_q         <= 1'b0;
      end else begin
         bus.req_ready <= (state_next == IDLE);
         bus.rsp_valid <= (state_next == RESP);
         bus.mem_we    <= 1'b0;
         bus.mem_re    <= 1'b0;

         if ((state == IDLE) && accept) begin
            if (req_err == '0) begin
               bus.mem_addr  <= bus.req_addr;
               bus.mem_wdata <= bus.req_wdata;
               bus.mem_size  <= size_t'(bus.req_op[1:0]);
               bus.mem_we    <= bus.req_we;
               bus.mem_re    <= ~bus.req_we;
               uns_q         <= bus.req_op[OP_UNSIGNED];
            end else begin
               bus.rsp_rdata <= '0;
               bus.rsp_err   <= req_err;
            end
         end

         if (state == ACCESS) begin
            bus.rsp_rdata <= bus.mem_re ? load_data : '0;
            bus.rsp_err   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Bench for mem_access_unit: a behavioural word memory with byte-lane merge
//   sits on the memory port, and a byte-addressed reference model predicts
//   error codes and load results from the access rules.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;
   import mem_access_pkg::*;

   logic clock;
   logic reset_n;
   logic mem_init;

   mem_access_unit_if bus ();

   mem_access_unit #(.MEM_ADDR(16'h1000)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int unsigned cyc;
   always @(posedge clock) cyc <= cyc + 1;

   // ---------------- memory (256 bytes, asynchronous read) --------------
   logic [31:0] mem [64];

   function automatic logic [31:0] init_word(input int unsigned i);
      return (i + 1) * 32'h9E37_79B9;
   endfunction

   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

   always @(posedge clock) begin
      if (mem_init) begin
         for (int unsigned i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (bus.mem_we) begin
         case (bus.mem_size)
            SZ_BYTE: mem[bus.mem_addr[7:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_wdata[7:0];
            SZ_HALF: mem[bus.mem_addr[7:2]][{bus.mem_addr[1], 4'b0000} +: 16] <= bus.mem_wdata[15:0];
            default: mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
         endcase
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [256];

   function automatic int unsigned ref_bytes(input logic [2:0] op);
      case (op[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b11:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [1:0] ref_err(input logic [31:0] a, input logic [2:0] op);
      int unsigned n;
      logic [1:0]  e;
      n = ref_bytes(op);
      e = 2'b00;
      if (n == 0) e[0] = 1'b1;
      else if ((a % n) != 0) e[0] = 1'b1;
      if ((a >> 16) != 32'h0000_1000) e[1] = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
      int unsigned n;
      logic [31:0] v;
      logic [7:0]  ix;
      n = ref_bytes(op);
      v = '0;
      for (int unsigned k = 0; k < n; k++) begin
         ix = a[7:0] + 8'(k);
         v  = v | ({24'h0, ref_mem[ix]} << (8 * k));
      end
      if (!op[2] && n < 4 && v[8 * n - 1]) v = v - (32'h1 << (8 * n));
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
      int unsigned n;
      logic [7:0]  ix;
      n = ref_bytes(op);
      for (int unsigned k = 0; k < n; k++) begin
         ix = a[7:0] + 8'(k);
         ref_mem[ix] = d[8 * k +: 8];
      end
   endtask

   // ---------------- checking ----------------
   int checks;
   int errors;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   int unsigned last_acc;
   int unsigned prev_acc;

   // One complete transaction starting at a negedge; returns at a negedge
   // after the response handshake. hold = cycles rsp_ready is kept low.
   task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input int unsigned hold,
                         output logic [31:0] got_data, output logic [1:0] got_err);
      logic [1:0]  exp_err;
      logic [31:0] exp_data;
      int unsigned n;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check_eq("req_ready_wait", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      exp_err = ref_err(addr, op);
      @(posedge clock);
      @(negedge clock);
      prev_acc = last_acc;
      last_acc = cyc;
      // scramble request fields so only latched values can be used
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_we    = 1'($urandom_range(0, 1));
      bus.req_op    = 3'($urandom);
      if (exp_err != 2'b00) begin
         exp_data = '0;
         check_eq("err_rsp_valid_n1", 32'(bus.rsp_valid), 32'd1);
      end else begin
         check_eq("acc_rsp_valid_n1", 32'(bus.rsp_valid), 32'd0);
         check_eq("acc_mem_we", 32'(bus.mem_we), 32'(we));
         check_eq("acc_mem_re", 32'(bus.mem_re), 32'(!we));
         check_eq("acc_mem_addr", bus.mem_addr, addr);
         check_eq("acc_mem_size", 32'(bus.mem_size), 32'(op[1:0]));
         check_eq("acc_req_ready", 32'(bus.req_ready), 32'd0);
         if (we) check_eq("acc_mem_wdata", bus.mem_wdata, wdata);
         @(negedge clock);
         check_eq("acc_rsp_valid_n2", 32'(bus.rsp_valid), 32'd1);
         if (we) begin
            exp_data = '0;
            ref_store(addr, op, wdata);
         end else begin
            exp_data = ref_load(addr, op);
         end
      end
      got_data = bus.rsp_rdata;
      got_err  = bus.rsp_err;
      for (int unsigned h = 0; h <= hold; h++) begin
         check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check_eq("rsp_rdata", bus.rsp_rdata, exp_data);
         check_eq("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
         check_eq("rsp_req_ready", 32'(bus.req_ready), 32'd0);
         check_eq("rsp_mem_idle", 32'(bus.mem_we | bus.mem_re), 32'd0);
         if (h < hold) begin
            bus.req_valid = 1'b1;   // competing request must not be taken
            @(negedge clock);
         end
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      bus.rsp_ready = 1'b0;
      check_eq("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("hs_req_ready", 32'(bus.req_ready), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] gd;
   logic [1:0]  ge;
   logic [31:0] w0;

   initial begin
      checks = 0;
      errors = 0;
      last_acc = 0;
      prev_acc = 0;
      for (int unsigned i = 0; i < 64; i++) begin
         w0 = init_word(i);
         for (int unsigned k = 0; k < 4; k++) ref_mem[8'(i * 4 + k)] = w0[8 * k +: 8];
      end
      reset_n       = 1'b0;
      mem_init      = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_op    = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check_eq("rst_mem_we_re", 32'({bus.mem_we, bus.mem_re}), 32'd0);
      check_eq("rst_mem_addr", bus.mem_addr, 32'd0);
      check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
      reset_n  = 1'b1;
      mem_init = 1'b0;
      #1;
      check_eq("rel_req_ready_low", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
      check_eq("rel_req_ready_high", 32'(bus.req_ready), 32'd1);

      // directed sequence
      do_req(1'b1, 3'b011, 32'h1000_0004, 32'hDEAD_BEEF, 0, gd, ge);
      do_req(1'b0, 3'b011, 32'h1000_0004, 32'h0, 0, gd, ge);
      check_eq("tp_lw", gd, 32'hDEAD_BEEF);
      check_eq("tp_lw_err", 32'(ge), 32'd0);
      check_eq("tp_spacing", last_acc - prev_acc, 32'd3);
      do_req(1'b0, 3'b000, 32'h1000_0007, 32'h0, 0, gd, ge);
      check_eq("tp_lb", gd, 32'hFFFF_FFDE);
      do_req(1'b0, 3'b100, 32'h1000_0007, 32'h0, 0, gd, ge);
      check_eq("tp_lbu", gd, 32'h0000_00DE);
      do_req(1'b0, 3'b001, 32'h1000_0006, 32'h0, 0, gd, ge);
      check_eq("tp_lh", gd, 32'hFFFF_DEAD);
      do_req(1'b0, 3'b101, 32'h1000_0006, 32'h0, 0, gd, ge);
      check_eq("tp_lhu", gd, 32'h0000_DEAD);
      do_req(1'b1, 3'b000, 32'h1000_0005, 32'h0000_0012, 0, gd, ge);
      do_req(1'b0, 3'b011, 32'h1000_0004, 32'h0, 0, gd, ge);
      check_eq("tp_sb_merge", gd, 32'hDEAD_12EF);
      do_req(1'b0, 3'b011, 32'h1000_0002, 32'h0, 0, gd, ge);
      check_eq("tp_err_align", 32'(ge), 32'd1);
      do_req(1'b1, 3'b011, 32'h2000_0000, 32'h5555_AAAA, 0, gd, ge);
      check_eq("tp_err_range", 32'(ge), 32'd2);
      do_req(1'b0, 3'b001, 32'h2000_0001, 32'h0, 0, gd, ge);
      check_eq("tp_err_both", 32'(ge), 32'd3);
      check_eq("tp_err_rdata", gd, 32'd0);
      do_req(1'b0, 3'b011, 32'h1000_0004, 32'h0, 5, gd, ge);
      check_eq("tp_hold_lw", gd, 32'hDEAD_12EF);

      // reset while a store sits in ACCESS
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_op    = 3'b011;
      bus.req_addr  = 32'h1000_0008;
      bus.req_wdata = 32'hCAFE_F00D;
      @(posedge clock);
      #2;
      check_eq("mid_mem_we_pre", 32'(bus.mem_we), 32'd1);
      reset_n = 1'b0;
      #1;
      check_eq("mid_mem_we_async", 32'(bus.mem_we), 32'd0);
      check_eq("mid_req_ready", 32'(bus.req_ready), 32'd0);
      check_eq("mid_mem_addr", bus.mem_addr, 32'd0);
      bus.req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      check_eq("mid_rel_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clock);
      check_eq("mid_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check_eq("mid_req_ready_up", 32'(bus.req_ready), 32'd1);
      do_req(1'b0, 3'b011, 32'h1000_0008, 32'h0, 0, gd, ge);
      check_eq("mid_prior_contents", gd, init_word(2));

      // randomized traffic
      for (int unsigned t = 0; t < 300; t++) begin
         logic        rwe;
         logic [2:0]  rop;
         logic [31:0] ra;
         rwe = 1'($urandom_range(0, 1));
         rop = 3'($urandom);
         if ($urandom_range(0, 9) == 0) ra = $urandom;
         else ra = {16'h1000, 8'h00, 8'($urandom)};
         if ($urandom_range(0, 3) != 0) begin
            if (rop[1:0] == 2'b01) ra[0] = 1'b0;
            if (rop[1:0] == 2'b11) ra[1:0] = 2'b00;
         end
         do_req(rwe, rop, ra, $urandom, $urandom_range(0, 3), gd, ge);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
